mux_nto1_stream: RTL and testbench
==================================

# mux_nto1_stream

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes, a registered output stage, and two selection modes: fixed (external select) and round-robin. It replaces the combinational 4x1 selector wherever several producers share one consumer. Data crosses one register stage. Back-pressure propagates to the selected source only.

## Interface
Parameters:
- WIDTH, 4: data width per channel.
- N, 4: number of input channels; N >= 2.
- SEL_W, derived localparam = clog2(N): select and grant width.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- Data_in  in  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- Valid_in  in  N  per-channel valid.
- Ready_in  out  N  per-channel ready; at most one bit high in any cycle.
- Sel  in  SEL_W  channel select, used in fixed mode only.
- Mode  in  1  0 = fixed select, 1 = round-robin.
- Data_out  out  WIDTH  registered output data.
- Valid_out  out  1  registered output valid.
- Ready_out  in  1  downstream ready.
- Grant  out  SEL_W  index of the channel whose word is in Data_out.

## Operation
- Output register: one entry holding Data_out, Grant and Valid_out.
- load_en = !Valid_out || Ready_out. The register accepts a new word when it is empty or is being drained in the same cycle.
- Candidate channel c, computed combinationally each cycle:
  - Fixed mode: c = Sel. If Sel >= N (non-power-of-2 N), there is no candidate.
  - Round-robin mode: search from ptr+1 upward, wrapping modulo N. The first i with Valid_in[i]=1 is the candidate. If no input is valid, there is no candidate.
- Ready_in[c] = load_en. All other Ready_in bits are 0. With no candidate, Ready_in = 0.
- Transfer on channel c when Valid_in[c] && Ready_in[c]. On transfer:
  - Data_out <= Data_in[c].
  - Grant <= c.
  - Valid_out <= 1.
  - In round-robin mode, ptr <= c.
- When load_en=1 and there is no transfer: Valid_out <= 0. Data_out and Grant hold their last values.
- Stall (Valid_out=1, Ready_out=0): Data_out, Grant and Valid_out hold. All Ready_in bits are 0.
- ptr has SEL_W bits and is not a port.
  - It updates only on round-robin transfers.
  - It is retained across mode changes.
  - Fixed-mode transfers do not move it.
- Mode and Sel changes take effect in the same cycle's combinational selection. No pending state needs to be flushed.
- Ready_in depends combinationally on Valid_in (round-robin search), Sel, Mode, Valid_out and Ready_out. Sources must not make Valid_in depend on Ready_in.
- Reset values:
  - Data_out = 0.
  - Valid_out = 0.
  - Grant = 0.
  - ptr = N-1, so channel 0 has highest priority first.
  - Ready_in is all 0 during the reset cycle.

## Timing
- Latency: a word accepted at edge k is visible on Data_out/Valid_out after edge k. It is consumed at the first later edge where Ready_out=1.
- Throughput: one word per cycle while Ready_out stays high. There are no bubbles under a continuous valid source.
- Simultaneous drain and load: the output register is overwritten with the new word on the same edge. No cycle is lost.
- Round-robin fairness: with all N inputs continuously valid and Ready_out=1, grants cycle 0,1,...,N-1,0,...
- Reset mid-operation: the word in the output register is discarded, and the outputs take their reset values on that edge. Ready_in=0 while rst=1. The first transfer after release is on channel 0 if Valid_in[0]=1.

## Test plan
- Reset: assert rst with Valid_in all 1 -> Ready_in=0. After the reset edge: Valid_out=0, Data_out=0, Grant=0.
- Fixed mode, N=4, WIDTH=4, Sel=2, Data_in ch2=4'hA, Valid_in=4'b0100, Ready_out=1 -> Ready_in=4'b0100. Next cycle: Data_out=4'hA, Grant=2, Valid_out=1.
- Back-pressure: hold Ready_out=0 for 3 cycles with Valid_out=1 -> Data_out, Grant and Valid_out are stable. Ready_in=0. No word is lost or duplicated when Ready_out returns to 1.
- Round-robin, all Valid_in=1, ch i data = i+5, Ready_out=1 for 6 cycles -> Grant sequence 0,1,2,3,0,1. Data_out sequence 5,6,7,8,5,6.
- Round-robin skip: Valid_in=4'b1010 after a grant on ch1 -> next Grant=3, then Grant=1. Channels 0 and 2 never receive Ready_in.
- Boundary, N=3: fixed mode with Sel=3 -> Ready_in=0 and no transfer. Valid_out falls to 0 after the last word drains. Assert rst mid-stream -> outputs reset, and the first post-reset grant is ch0.

Source files
------------

// File: rtl/mux_nto1_stream.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
// Channel choice is either an external select or a round-robin search.
module mux_nto1_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   Data_in,
    input  logic [N-1:0]         Valid_in,
    output logic [N-1:0]         Ready_in,
    input  logic [SEL_W-1:0]     Sel,
    input  logic                 Mode,
    output logic [WIDTH-1:0]     Data_out,
    output logic                 Valid_out,
    input  logic                 Ready_out,
    output logic [SEL_W-1:0]     Grant
);

    logic [WIDTH-1:0] din [N];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cand;
    logic             cand_vld;
    logic [SEL_W-1:0] idx;
    logic             load_en;
    logic             xfer;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign din[i] = Data_in[i*WIDTH +: WIDTH];
    end

    assign load_en = !Valid_out || Ready_out;

    // Candidate channel: external select, or first valid channel after ptr
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        idx      = '0;
        if (!Mode) begin
            if (32'(Sel) < N) begin
                cand     = Sel;
                cand_vld = 1'b1;
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = SEL_W'((32'(ptr) + k) % N);
                if (!cand_vld && Valid_in[idx]) begin
                    cand     = idx;
                    cand_vld = 1'b1;
                end
            end
        end
    end

    // Only the candidate sees ready; nothing is accepted while in reset
    always_comb begin
        Ready_in = '0;
        if (cand_vld && !rst) begin
            Ready_in[cand] = load_en;
        end
    end

    assign xfer = cand_vld && !rst && load_en && Valid_in[cand];

    always_ff @(posedge clk) begin
        if (rst) begin
            Data_out  <= '0;
            Valid_out <= 1'b0;
            Grant     <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (load_en) begin
            if (xfer) begin
                Data_out  <= din[cand];
                Grant     <= cand;
                Valid_out <= 1'b1;
                if (Mode) begin
                    ptr <= cand;
                end
            end else begin
                Valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench for mux_nto1_stream: vector table on an N=4 instance with
// an output scoreboard, plus hand sequences on an N=3 instance.
module tb_mux_nto1_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4, WIDTH=4 instance
    logic        rst;
    logic [15:0] din;
    logic [3:0]  vin;
    logic [3:0]  rdy;
    logic [1:0]  sel;
    logic        mode;
    logic [3:0]  dout;
    logic        vout;
    logic        rout;
    logic [1:0]  grant;

    // N=3, WIDTH=4 instance
    logic        rst3;
    logic [11:0] din3;
    logic [2:0]  vin3;
    logic [2:0]  rdy3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [3:0]  dout3;
    logic        vout3;
    logic        rout3;
    logic [1:0]  grant3;

    mux_nto1_stream #(.WIDTH(4), .N(4)) u_dut (
        .clk(clk), .rst(rst), .Data_in(din), .Valid_in(vin), .Ready_in(rdy),
        .Sel(sel), .Mode(mode), .Data_out(dout), .Valid_out(vout),
        .Ready_out(rout), .Grant(grant)
    );

    mux_nto1_stream #(.WIDTH(4), .N(3)) u_dut3 (
        .clk(clk), .rst(rst3), .Data_in(din3), .Valid_in(vin3), .Ready_in(rdy3),
        .Sel(sel3), .Mode(mode3), .Data_out(dout3), .Valid_out(vout3),
        .Ready_out(rout3), .Grant(grant3)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vin;
        logic        rout;
        logic [15:0] din;
        logic [3:0]  exp_rdy;
        logic        exp_vo;
        logic [1:0]  exp_gr;
        logic [3:0]  exp_do;
    } vec_t;

    localparam int unsigned NVEC = 19;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consume the word leaving the output register, record words entering it
    task automatic sb_sample(input int r);
        logic [5:0] e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (vout && rout) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("sb_unexpected_r%0d", r), {26'd0, dout, grant}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("sb_word_r%0d", r), {26'd0, dout, grant}, {26'd0, e});
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (vin[i] && rdy[i]) begin
                    sb_q.push_back({din[i*4 +: 4], 2'(i)});
                end
            end
        end
    endtask

    task automatic step4(input vec_t v, input int r);
        mode = v.mode; sel = v.sel; vin = v.vin; rout = v.rout; din = v.din;
        @(negedge clk);
        chk($sformatf("ready_in_r%0d", r), 32'(rdy), 32'(v.exp_rdy));
        sb_sample(r);
        @(posedge clk); #1;
        chk($sformatf("valid_out_r%0d", r), 32'(vout), 32'(v.exp_vo));
        chk($sformatf("grant_r%0d", r), 32'(grant), 32'(v.exp_gr));
        chk($sformatf("data_out_r%0d", r), 32'(dout), 32'(v.exp_do));
    endtask

    task automatic step3(input string name, input logic r, input logic m, input logic [1:0] s,
                         input logic [2:0] v, input logic ro, input logic [2:0] e_rdy,
                         input logic e_vo, input logic [1:0] e_gr, input logic [3:0] e_do);
        rst3 = r; mode3 = m; sel3 = s; vin3 = v; rout3 = ro;
        @(negedge clk);
        chk({name, "_ready_in"}, 32'(rdy3), 32'(e_rdy));
        @(posedge clk); #1;
        chk({name, "_valid_out"}, 32'(vout3), 32'(e_vo));
        chk({name, "_grant"}, 32'(grant3), 32'(e_gr));
        chk({name, "_data_out"}, 32'(dout3), 32'(e_do));
    endtask

    initial begin
        //             mode sel   vin      rout  din       rdy      vo    gr    do
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 16'h8A65, 4'b0100, 1'b1, 2'd2, 4'hA};
        vecs[1]  = '{1'b0, 2'd2, 4'b0100, 1'b0, 16'h8A65, 4'b0000, 1'b1, 2'd2, 4'hA};
        vecs[2]  = '{1'b0, 2'd2, 4'b0100, 1'b0, 16'h8A65, 4'b0000, 1'b1, 2'd2, 4'hA};
        vecs[3]  = '{1'b0, 2'd2, 4'b0100, 1'b0, 16'h8A65, 4'b0000, 1'b1, 2'd2, 4'hA};
        vecs[4]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 16'h8A65, 4'b0100, 1'b0, 2'd2, 4'hA};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b0001, 1'b1, 2'd0, 4'h5};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b0010, 1'b1, 2'd1, 4'h6};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b0100, 1'b1, 2'd2, 4'h7};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b1000, 1'b1, 2'd3, 4'h8};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b0001, 1'b1, 2'd0, 4'h5};
        vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b0010, 1'b1, 2'd1, 4'h6};
        vecs[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 16'h8765, 4'b1000, 1'b1, 2'd3, 4'h8};
        vecs[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 16'h8765, 4'b0010, 1'b1, 2'd1, 4'h6};
        vecs[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, 16'h8765, 4'b0000, 1'b0, 2'd1, 4'h6};
        vecs[14] = '{1'b0, 2'd0, 4'b0001, 1'b1, 16'h8765, 4'b0001, 1'b1, 2'd0, 4'h5};
        vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b0100, 1'b1, 2'd2, 4'h7};
        vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 16'h8765, 4'b0000, 1'b1, 2'd2, 4'h7};
        vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h8765, 4'b1000, 1'b1, 2'd3, 4'h8};
        vecs[18] = '{1'b0, 2'd1, 4'b0001, 1'b1, 16'h8765, 4'b0010, 1'b0, 2'd3, 4'h8};

        // Reset both instances with every input valid
        rst = 1'b1; din = 16'h8765; vin = 4'b1111; sel = 2'd0; mode = 1'b1; rout = 1'b1;
        rst3 = 1'b1; din3 = 12'h943; vin3 = 3'b111; sel3 = 2'd0; mode3 = 1'b1; rout3 = 1'b1;
        @(negedge clk);
        chk("reset_ready_in", 32'(rdy), 32'd0);
        chk("reset_ready_in_n3", 32'(rdy3), 32'd0);
        @(posedge clk); #1;
        chk("reset_valid_out", 32'(vout), 32'd0);
        chk("reset_data_out", 32'(dout), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_valid_out_n3", 32'(vout3), 32'd0);
        rst = 1'b0; rst3 = 1'b0; vin3 = 3'b000;

        for (int r = 0; r < int'(NVEC); r++) begin
            step4(vecs[r], r);
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // N=3: out-of-range select, round-robin, reset mid-stream
        step3("n3_fixed_sel0",   1'b0, 1'b0, 2'd0, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 4'h3);
        step3("n3_sel_oor",      1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 4'h3);
        step3("n3_rr_first",     1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 4'h3);
        step3("n3_rr_second",    1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 4'h4);
        step3("n3_mid_reset",    1'b1, 1'b1, 2'd0, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0, 4'h0);
        step3("n3_post_reset",   1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 4'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
